triangle_bbox_scanner: RTL and testbench

Per-triangle pixel scan generator between `triangle_3d_to_2d` and `triangle_2d_fill`. It replaces the free-running full-frame hcount/vcount sweep with a scan of only the triangle's screen bounding box. The box is clamped to the frame. Each triangle is accepted over a valid/ready handshake, and the block then emits one candidate pixel per cycle under backpressure. The triangle and its colour travel alongside every pixel, so the fill stage and framebuffer writer need no separate alignment pipe.

---
 rtl/triangle_bbox_scanner_pkg.sv | 36 +++
 rtl/triangle_bbox_scanner_if.sv | 33 +++
 rtl/triangle_bbox_scanner_bbox_compute.sv | 19 +
 rtl/triangle_bbox_scanner.sv | 150 +++++++++++++++
 tb/tb_triangle_bbox_scanner.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/triangle_bbox_scanner_pkg.sv
// Shared types and constants for the triangle bounding-box scanner.
// Contents: coordinate/vertex/triangle types, bbox_t, frame size constants,
// and signed min/max helpers used by the bounding-box logic.
package triangle_bbox_scanner_pkg;

  localparam int unsigned COORD_BITS   = 16;
  localparam int unsigned COL_BITS     = 16;
  localparam int unsigned FRAME_WIDTH  = 512;
  localparam int unsigned FRAME_HEIGHT = 384;

  typedef logic signed [COORD_BITS-1:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } vertex_t;

  // Three screen-space vertices, index 0..2.
  typedef vertex_t [2:0] tri_2d;

  typedef struct packed {
    coord_t xmin;
    coord_t xmax;
    coord_t ymin;
    coord_t ymax;
  } bbox_t;

  function automatic coord_t smin(input coord_t a, input coord_t b);
    return (a < b) ? a : b;
  endfunction

  function automatic coord_t smax(input coord_t a, input coord_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/triangle_bbox_scanner_if.sv
// Handshake bundle between the triangle source, the scanner and the fill stage.
// Triangle side: tri_valid/tri_ready, tri_in, tri_col.
// Pixel side:    pix_valid/pix_ready, hcount, vcount, pix_tri, pix_col,
//                pix_last, tri_done.
// master = triangle producer / pixel consumer; slave = scanner.
interface triangle_bbox_scanner_if;
  import triangle_bbox_scanner_pkg::*;

  logic                  tri_valid;
  logic                  tri_ready;
  tri_2d                 tri_in;
  logic [COL_BITS-1:0]   tri_col;

  logic                  pix_valid;
  logic                  pix_ready;
  logic [COORD_BITS-1:0] hcount;
  logic [COORD_BITS-1:0] vcount;
  tri_2d                 pix_tri;
  logic [COL_BITS-1:0]   pix_col;
  logic                  pix_last;
  logic                  tri_done;

  modport master (
    output tri_valid, tri_in, tri_col, pix_ready,
    input  tri_ready, pix_valid, hcount, vcount, pix_tri, pix_col, pix_last, tri_done
  );

  modport slave (
    input  tri_valid, tri_in, tri_col, pix_ready,
    output tri_ready, pix_valid, hcount, vcount, pix_tri, pix_col, pix_last, tri_done
  );

endinterface

// File: rtl/triangle_bbox_scanner_bbox_compute.sv
// Combinational signed min3/max3 over the three vertices of a triangle.
// Ports: i_tri  - triangle vertices
//        o_bbox - unclamped signed bounding box
module triangle_bbox_scanner_bbox_compute
  import triangle_bbox_scanner_pkg::*;
(
  input  tri_2d i_tri,
  output bbox_t o_bbox
);

  always_comb begin
    o_bbox      = '0;
    o_bbox.xmin = smin(smin(i_tri[0].x, i_tri[1].x), i_tri[2].x);
    o_bbox.xmax = smax(smax(i_tri[0].x, i_tri[1].x), i_tri[2].x);
    o_bbox.ymin = smin(smin(i_tri[0].y, i_tri[1].y), i_tri[2].y);
    o_bbox.ymax = smax(smax(i_tri[0].y, i_tri[1].y), i_tri[2].y);
  end

endmodule

// File: rtl/triangle_bbox_scanner.sv
// Per-triangle raster generator: accepts one triangle, scans only its
// frame-clamped bounding box, one candidate pixel per cycle under backpressure.
// Ports: clk - system clock
//        rst - asynchronous active-low reset
//        bus - slave side of triangle_bbox_scanner_if (triangle in, pixels out)
module triangle_bbox_scanner #(
  parameter int unsigned FRAME_WIDTH  = triangle_bbox_scanner_pkg::FRAME_WIDTH,
  parameter int unsigned FRAME_HEIGHT = triangle_bbox_scanner_pkg::FRAME_HEIGHT,
  // Must match the package coordinate width carried on the interface.
  parameter int unsigned COORD_BITS   = triangle_bbox_scanner_pkg::COORD_BITS
) (
  input  logic                   clk,
  input  logic                   rst,
  triangle_bbox_scanner_if.slave bus
);
  import triangle_bbox_scanner_pkg::*;

  localparam coord_t X_LIM = coord_t'(FRAME_WIDTH - 1);
  localparam coord_t Y_LIM = coord_t'(FRAME_HEIGHT - 1);

  typedef enum logic [1:0] {S_IDLE, S_BOUND, S_CLAMP, S_SCAN} state_e;

  state_e                r_state;
  tri_2d                 r_tri;
  logic [COL_BITS-1:0]   r_col;
  bbox_t                 r_bbox;
  logic [COORD_BITS-1:0] r_xmin;
  logic [COORD_BITS-1:0] r_xmax;
  logic [COORD_BITS-1:0] r_ymax;
  logic [COORD_BITS-1:0] r_hcount;
  logic [COORD_BITS-1:0] r_vcount;
  logic                  r_tri_ready;
  logic                  r_pix_valid;
  logic                  r_pix_last;
  logic                  r_tri_done;

  bbox_t                 w_bbox;
  coord_t                w_cxmin;
  coord_t                w_cxmax;
  coord_t                w_cymin;
  coord_t                w_cymax;
  logic                  w_empty;
  logic [COORD_BITS-1:0] w_hnext;
  logic [COORD_BITS-1:0] w_vnext;

  triangle_bbox_scanner_bbox_compute u_bbox_compute (
    .i_tri  (r_tri),
    .o_bbox (w_bbox)
  );

  // Clamp the registered box to the frame; signed so off-screen-left/top works.
  always_comb begin
    w_cxmin = smax(r_bbox.xmin, coord_t'(0));
    w_cxmax = smin(r_bbox.xmax, X_LIM);
    w_cymin = smax(r_bbox.ymin, coord_t'(0));
    w_cymax = smin(r_bbox.ymax, Y_LIM);
    w_empty = (w_cxmin > w_cxmax) || (w_cymin > w_cymax);
  end

  // Next raster position; only consumed when the current pixel is not last.
  // Clamped bounds are non-negative, so unsigned compares are safe here.
  always_comb begin
    w_hnext = r_hcount;
    w_vnext = r_vcount;
    if (r_hcount < r_xmax) begin
      w_hnext = r_hcount + COORD_BITS'(1);
    end else begin
      w_hnext = r_xmin;
      w_vnext = r_vcount + COORD_BITS'(1);
    end
  end

  // Control FSM and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_tri       <= '0;
      r_col       <= '0;
      r_bbox      <= '0;
      r_xmin      <= '0;
      r_xmax      <= '0;
      r_ymax      <= '0;
      r_hcount    <= '0;
      r_vcount    <= '0;
      r_tri_ready <= 1'b0;
      r_pix_valid <= 1'b0;
      r_pix_last  <= 1'b0;
      r_tri_done  <= 1'b0;
    end else begin
      r_tri_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_tri_ready <= 1'b1;
          if (bus.tri_valid && r_tri_ready) begin
            r_tri       <= bus.tri_in;
            r_col       <= bus.tri_col;
            r_tri_ready <= 1'b0;
            r_state     <= S_BOUND;
          end
        end
        S_BOUND: begin
          r_bbox  <= w_bbox;
          r_state <= S_CLAMP;
        end
        S_CLAMP: begin
          if (w_empty) begin
            r_tri_done  <= 1'b1;
            r_tri_ready <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            r_xmin      <= COORD_BITS'(w_cxmin);
            r_xmax      <= COORD_BITS'(w_cxmax);
            r_ymax      <= COORD_BITS'(w_cymax);
            r_hcount    <= COORD_BITS'(w_cxmin);
            r_vcount    <= COORD_BITS'(w_cymin);
            r_pix_valid <= 1'b1;
            r_pix_last  <= (w_cxmin == w_cxmax) && (w_cymin == w_cymax);
            r_state     <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (r_pix_valid && bus.pix_ready) begin
            if (r_pix_last) begin
              r_pix_valid <= 1'b0;
              r_pix_last  <= 1'b0;
              r_tri_done  <= 1'b1;
              r_tri_ready <= 1'b1;
              r_state     <= S_IDLE;
            end else begin
              r_hcount   <= w_hnext;
              r_vcount   <= w_vnext;
              r_pix_last <= (w_hnext == r_xmax) && (w_vnext == r_ymax);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.tri_ready = r_tri_ready;
  assign bus.pix_valid = r_pix_valid;
  assign bus.hcount    = r_hcount;
  assign bus.vcount    = r_vcount;
  assign bus.pix_tri   = r_tri;
  assign bus.pix_col   = r_col;
  assign bus.pix_last  = r_pix_last;
  assign bus.tri_done  = r_tri_done;

endmodule

// File: tb/tb_triangle_bbox_scanner.sv
// Scoreboard bench for triangle_bbox_scanner: stimulus pushes expected pixels,
// a negedge monitor pops and compares on every pixel handshake.
module tb_triangle_bbox_scanner;
  import triangle_bbox_scanner_pkg::*;

  typedef struct {
    logic [15:0] h;
    logic [15:0] v;
    logic        last;
    tri_2d       tr;
    logic [15:0] col;
  } exp_t;

  logic clk;
  logic rst;
  logic rand_ready;

  triangle_bbox_scanner_if u_if ();

  triangle_bbox_scanner #(
    .FRAME_WIDTH  (512),
    .FRAME_HEIGHT (384),
    .COORD_BITS   (16)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  exp_t exp_q[$];
  int   n_checks  = 0;
  int   n_errors  = 0;
  int   hs_cnt    = 0;
  int   done_cnt  = 0;
  int   exp_done  = 0;
  logic prev_stall = 1'b0;
  exp_t held;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic tri_2d make_tri(input int x0, input int y0, input int x1,
                                     input int y1, input int x2, input int y2);
    tri_2d t;
    t[0].x = coord_t'(x0); t[0].y = coord_t'(y0);
    t[1].x = coord_t'(x1); t[1].y = coord_t'(y1);
    t[2].x = coord_t'(x2); t[2].y = coord_t'(y2);
    return t;
  endfunction

  // Push the raster of a hand-computed clamped box; limit<0 means whole box.
  task automatic push_box(input tri_2d t, input logic [15:0] col, input int x0, input int x1,
                          input int y0, input int y1, input int limit);
    int n;
    n = 0;
    for (int y = y0; y <= y1; y++) begin
      for (int x = x0; x <= x1; x++) begin
        exp_t e;
        if (limit < 0 || n < limit) begin
          e.h    = 16'(x);
          e.v    = 16'(y);
          e.last = (x == x1) && (y == y1);
          e.tr   = t;
          e.col  = col;
          exp_q.push_back(e);
        end
        n++;
      end
    end
  endtask

  // Random or full-rate downstream ready, changed just after each rising edge.
  always @(posedge clk) begin
    #1;
    u_if.pix_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // Monitor: pops the scoreboard on handshakes and checks stall stability.
  always @(negedge clk) begin
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      if (u_if.tri_done) done_cnt++;
      if (prev_stall) begin
        check("stall_valid", 96'(u_if.pix_valid), 96'(1));
        check("stall_h",     96'(u_if.hcount),    96'(held.h));
        check("stall_v",     96'(u_if.vcount),    96'(held.v));
        check("stall_last",  96'(u_if.pix_last),  96'(held.last));
        check("stall_tri",   96'(u_if.pix_tri),   96'(held.tr));
        check("stall_col",   96'(u_if.pix_col),   96'(held.col));
      end
      if (u_if.pix_valid && u_if.pix_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_pixel: got (%0d,%0d) expected none", u_if.hcount, u_if.vcount);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("pix_h",    96'(u_if.hcount),   96'(e.h));
          check("pix_v",    96'(u_if.vcount),   96'(e.v));
          check("pix_last", 96'(u_if.pix_last), 96'(e.last));
          check("pix_tri",  96'(u_if.pix_tri),  96'(e.tr));
          check("pix_col",  96'(u_if.pix_col),  96'(e.col));
        end
      end
      prev_stall = u_if.pix_valid && !u_if.pix_ready;
      held.h    = u_if.hcount;
      held.v    = u_if.vcount;
      held.last = u_if.pix_last;
      held.tr   = u_if.pix_tri;
      held.col  = u_if.pix_col;
    end
  end

  task automatic send(input tri_2d t, input logic [15:0] col);
    logic ok;
    ok = 1'b0;
    @(posedge clk); #1;
    u_if.tri_in    = t;
    u_if.tri_col   = col;
    u_if.tri_valid = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (u_if.tri_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("send_accept", 96'(ok), 96'(1));
    @(posedge clk); #1;
    u_if.tri_valid = 1'b0;
  endtask

  // Checks the three negedges following acceptance.
  task automatic probe_latency(input logic empty, input logic [15:0] h0, input logic [15:0] v0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("lat_pix_valid", 96'(u_if.pix_valid), 96'((k == 3) && !empty));
      check("lat_tri_done",  96'(u_if.tri_done),  96'((k == 3) && empty));
      if (k == 3 && !empty) begin
        check("first_h", 96'(u_if.hcount), 96'(h0));
        check("first_v", 96'(u_if.vcount), 96'(v0));
      end
      if (k == 3 && empty) check("empty_ready", 96'(u_if.tri_ready), 96'(1));
    end
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk); #1;
      if (done_cnt >= exp_done) break;
    end
    check(name, 96'(done_cnt), 96'(exp_done));
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_tri_ready"}, 96'(u_if.tri_ready), 96'(0));
    check({name, "_pix_valid"}, 96'(u_if.pix_valid), 96'(0));
    check({name, "_pix_last"},  96'(u_if.pix_last),  96'(0));
    check({name, "_tri_done"},  96'(u_if.tri_done),  96'(0));
    check({name, "_hcount"},    96'(u_if.hcount),    96'(0));
    check({name, "_vcount"},    96'(u_if.vcount),    96'(0));
    check({name, "_pix_tri"},   96'(u_if.pix_tri),   96'(0));
    check({name, "_pix_col"},   96'(u_if.pix_col),   96'(0));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tri_2d t;
    int    base;
    rst            = 1'b0;
    rand_ready     = 1'b0;
    u_if.tri_valid = 1'b0;
    u_if.tri_in    = '0;
    u_if.tri_col   = '0;
    u_if.pix_ready = 1'b1;
    #1;
    check_all_zero("reset");
    @(negedge clk); #2;
    rst = 1'b1;
    @(negedge clk);
    check("idle_ready", 96'(u_if.tri_ready), 96'(1));

    // Interior box x 10..30, y 5..25.
    t = make_tri(10, 20, 30, 5, 15, 25);
    push_box(t, 16'hA5C3, 10, 30, 5, 25, -1);
    exp_done++;
    base = hs_cnt;
    send(t, 16'hA5C3);
    probe_latency(1'b0, 16'd10, 16'd5);
    wait_done("t1_done");
    check("t1_count", 96'(hs_cnt - base), 96'(441));
    check("t1_queue", 96'(exp_q.size()), 96'(0));

    // Box clamped at the top-left corner to x 0..3, y 0..2.
    t = make_tri(-5, -5, 3, 2, 0, 1);
    push_box(t, 16'h1234, 0, 3, 0, 2, -1);
    exp_done++;
    base = hs_cnt;
    send(t, 16'h1234);
    probe_latency(1'b0, 16'd0, 16'd0);
    wait_done("t2_done");
    check("t2_count", 96'(hs_cnt - base), 96'(12));

    // Entirely right of the frame: no pixels.
    t = make_tri(600, 10, 700, 20, 650, 30);
    exp_done++;
    base = hs_cnt;
    send(t, 16'hFFFF);
    probe_latency(1'b1, 16'd0, 16'd0);
    wait_done("t3_done");
    check("t3_count", 96'(hs_cnt - base), 96'(0));

    // Single point.
    t = make_tri(100, 100, 100, 100, 100, 100);
    push_box(t, 16'h0F0F, 100, 100, 100, 100, -1);
    exp_done++;
    base = hs_cnt;
    send(t, 16'h0F0F);
    probe_latency(1'b0, 16'd100, 16'd100);
    wait_done("t4_done");
    check("t4_count", 96'(hs_cnt - base), 96'(1));

    // 8x8 box under random backpressure.
    t = make_tri(0, 0, 7, 0, 0, 7);
    push_box(t, 16'hBEEF, 0, 7, 0, 7, -1);
    exp_done++;
    base = hs_cnt;
    rand_ready = 1'b1;
    send(t, 16'hBEEF);
    wait_done("t5_done");
    rand_ready = 1'b0;
    check("t5_count", 96'(hs_cnt - base), 96'(64));
    check("t5_queue", 96'(exp_q.size()), 96'(0));

    // Reset in the middle of a scan: only 20 pixels, no tri_done.
    t = make_tri(10, 20, 30, 5, 15, 25);
    push_box(t, 16'h5555, 10, 30, 5, 25, 20);
    base = hs_cnt;
    send(t, 16'h5555);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (hs_cnt - base >= 20) break;
    end
    check("rst_hs_reached", 96'(hs_cnt - base), 96'(20));
    #1;
    rst = 1'b0;
    #1;
    check_all_zero("midrst");
    @(negedge clk); #2;
    rst = 1'b1;
    check("rst_queue", 96'(exp_q.size()), 96'(0));

    t = make_tri(1, 1, 2, 1, 1, 2);
    push_box(t, 16'h00C0, 1, 2, 1, 2, -1);
    exp_done++;
    base = hs_cnt;
    send(t, 16'h00C0);
    probe_latency(1'b0, 16'd1, 16'd1);
    wait_done("t6_done");
    check("t6_count", 96'(hs_cnt - base), 96'(4));

    repeat (5) @(negedge clk);
    check("final_done_count", 96'(done_cnt), 96'(exp_done));
    check("final_queue", 96'(exp_q.size()), 96'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
